// File: rtl/win_sprite_motion_if.sv
// Control/position bundle between the game logic, the win sprite motion block and the sprite renderer.
interface win_sprite_motion_if;
    logic        frame_tick;
    logic        win_trigger;
    logic        clear;
    logic [10:0] win_x;
    logic [9:0]  win_y;
    logic        win_visible;
    logic        settled;

    modport master (
        output frame_tick, win_trigger, clear,
        input  win_x, win_y, win_visible, settled
    );

    modport slave (
        input  frame_tick, win_trigger, clear,
        output win_x, win_y, win_visible, settled
    );
endinterface

// File: rtl/win_sprite_motion.sv
// Win sprite position generator: slides in from the top edge to centre, then bounces
// diagonally inside the active area, stepping once per frame_tick.
module win_sprite_motion #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned SPRITE   = 256,
    parameter int unsigned STEP     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    win_sprite_motion_if.slave bus
);

    localparam int unsigned X_MAX_I = H_ACTIVE - SPRITE;
    localparam int unsigned Y_MAX_I = V_ACTIVE - SPRITE;

    localparam logic [11:0] X_MAX_W = 12'(X_MAX_I);
    localparam logic [10:0] Y_MAX_W = 11'(Y_MAX_I);
    localparam logic [10:0] Y_CEN_W = 11'(Y_MAX_I / 2);
    localparam logic [11:0] STEP_XW = 12'(STEP);
    localparam logic [10:0] STEP_YW = 11'(STEP);
    localparam logic [10:0] X_MAX_O = 11'(X_MAX_I);
    localparam logic [9:0]  Y_MAX_O = 10'(Y_MAX_I);
    localparam logic [10:0] X_CEN_O = 11'(X_MAX_I / 2);
    localparam logic [9:0]  Y_CEN_O = 10'(Y_MAX_I / 2);

    typedef enum logic [1:0] {IDLE, ENTER, BOUNCE} state_e;
    typedef enum logic {DIR_FWD, DIR_REV} dir_e;

    state_e      state_q, state_d;
    dir_e        dir_x_q, dir_x_d;
    dir_e        dir_y_q, dir_y_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        visible_q, visible_d;
    logic        settled_q, settled_d;

    logic [11:0] x_inc;
    logic [10:0] y_inc;
    logic [10:0] x_dec;
    logic [9:0]  y_dec;

    always_comb begin
        state_d = state_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        x_d     = x_q;
        y_d     = y_q;
        // Widened sums so a step near the bound cannot wrap before the compare.
        x_inc   = {1'b0, x_q} + STEP_XW;
        y_inc   = {1'b0, y_q} + STEP_YW;
        x_dec   = x_q - 11'(STEP);
        y_dec   = y_q - 10'(STEP);

        if (bus.clear) begin
            state_d = IDLE;
            dir_x_d = DIR_FWD;
            dir_y_d = DIR_FWD;
            x_d     = X_CEN_O;
            y_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    dir_x_d = DIR_FWD;
                    dir_y_d = DIR_FWD;
                    x_d     = X_CEN_O;
                    y_d     = '0;
                    if (bus.win_trigger) state_d = ENTER;
                end
                ENTER: begin
                    x_d = X_CEN_O;
                    if (bus.frame_tick) begin
                        if (y_inc >= Y_CEN_W) begin
                            y_d     = Y_CEN_O;
                            state_d = BOUNCE;
                        end else begin
                            y_d = y_inc[9:0];
                        end
                    end
                end
                BOUNCE: begin
                    if (bus.frame_tick) begin
                        if (dir_x_q == DIR_FWD) begin
                            if (x_inc >= X_MAX_W) begin
                                x_d     = X_MAX_O;
                                dir_x_d = DIR_REV;
                            end else begin
                                x_d = x_inc[10:0];
                            end
                        end else if ({1'b0, x_q} <= STEP_XW) begin
                            x_d     = '0;
                            dir_x_d = DIR_FWD;
                        end else begin
                            x_d = x_dec;
                        end

                        if (dir_y_q == DIR_FWD) begin
                            if (y_inc >= Y_MAX_W) begin
                                y_d     = Y_MAX_O;
                                dir_y_d = DIR_REV;
                            end else begin
                                y_d = y_inc[9:0];
                            end
                        end else if ({1'b0, y_q} <= STEP_YW) begin
                            y_d     = '0;
                            dir_y_d = DIR_FWD;
                        end else begin
                            y_d = y_dec;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        visible_d = (state_d != IDLE);
        settled_d = (state_d == BOUNCE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            dir_x_q   <= DIR_FWD;
            dir_y_q   <= DIR_FWD;
            x_q       <= X_CEN_O;
            y_q       <= '0;
            visible_q <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            x_q       <= x_d;
            y_q       <= y_d;
            visible_q <= visible_d;
            settled_q <= settled_d;
        end
    end

    assign bus.win_x       = x_q;
    assign bus.win_y       = y_q;
    assign bus.win_visible = visible_q;
    assign bus.settled     = settled_q;

endmodule

// File: tb/tb_win_sprite_motion.sv
// Bench for win_sprite_motion: vector table through a scoreboard queue on a STEP=4 and a STEP=5
// instance, plus hand sequences for async reset and frame-to-frame position stability.
module tb_win_sprite_motion;

    logic clk;
    logic reset_n;

    win_sprite_motion_if bus_a ();
    win_sprite_motion_if bus_b ();

    win_sprite_motion u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    win_sprite_motion #(.STEP(5)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int dut;
        bit ft;
        bit wt;
        bit clr;
        int ex;
        int ey;
        bit ev;
        bit es;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(int d, bit ft, bit wt, bit clr, int ex, int ey, bit ev, bit es);
        vec_t v;
        v.dut = d; v.ft = ft; v.wt = wt; v.clr = clr;
        v.ex = ex; v.ey = ey; v.ev = ev; v.es = es;
        vecs.push_back(v);
    endfunction

    function automatic void chk(bit ok, string msg);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s", msg);
        end
    endfunction

    task automatic drive_idle();
        bus_a.frame_tick = 0; bus_a.win_trigger = 0; bus_a.clear = 0;
        bus_b.frame_tick = 0; bus_b.win_trigger = 0; bus_b.clear = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        int gx, gy;
        bit gv, gs;
        @(negedge clk);
        drive_idle();
        if (v.dut == 0) begin
            bus_a.frame_tick = v.ft; bus_a.win_trigger = v.wt; bus_a.clear = v.clr;
        end else begin
            bus_b.frame_tick = v.ft; bus_b.win_trigger = v.wt; bus_b.clear = v.clr;
        end
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.dut == 0) begin
            gx = int'(bus_a.win_x); gy = int'(bus_a.win_y); gv = bus_a.win_visible; gs = bus_a.settled;
        end else begin
            gx = int'(bus_b.win_x); gy = int'(bus_b.win_y); gv = bus_b.win_visible; gs = bus_b.settled;
        end
        chk(gx == e.ex && gy == e.ey && gv == e.ev && gs == e.es,
            $sformatf("vec[%0d] dut%0d: got x=%0d y=%0d vis=%0b set=%0b, want x=%0d y=%0d vis=%0b set=%0b",
                      idx, e.dut, gx, gy, gv, gs, e.ex, e.ey, e.ev, e.es));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int px, py, yk;
        bit ft;

        // ---------------- STEP=4 instance ----------------
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 192, 0, 0, 0);       // ticks ignored in IDLE
        add(0, 0, 1, 0, 192, 0, 1, 0);                                    // trigger -> ENTER
        for (int k = 1; k <= 27; k++) begin
            add(0, 1, (k == 10), 0, 192, 4 * k, 1, 0);                    // trigger at k=10 ignored
            if (k == 5) add(0, 0, 0, 0, 192, 20, 1, 0);                   // no tick: hold
        end
        add(0, 1, 0, 0, 192, 112, 1, 1);                                  // 28th tick: settled
        for (int k = 1; k <= 28; k++) add(0, 1, 0, 0, 192 + 4 * k, 112 + 4 * k, 1, 1);
        for (int k = 1; k <= 20; k++) add(0, 1, 0, 0, 304 + 4 * k, 224 - 4 * k, 1, 1);
        add(0, 1, 0, 0, 380, 140, 1, 1);
        add(0, 1, 0, 1, 192, 0, 0, 0);                                    // clear beats frame_tick
        add(0, 1, 1, 0, 192, 0, 1, 0);                                    // trigger+tick in IDLE: no step
        add(0, 1, 0, 0, 192, 4, 1, 0);
        add(0, 0, 1, 1, 192, 0, 0, 0);                                    // clear held beats trigger
        add(0, 1, 1, 1, 192, 0, 0, 0);
        // ---------------- STEP=5 instance ----------------
        add(1, 0, 1, 0, 192, 0, 1, 0);
        for (int k = 1; k <= 22; k++) add(1, 1, 0, 0, 192, 5 * k, 1, 0);
        add(1, 1, 0, 0, 192, 112, 1, 1);                                  // clamp 115 -> 112
        for (int k = 1; k <= 39; k++) begin
            if (k <= 22)      yk = 112 + 5 * k;
            else if (k == 23) yk = 224;
            else              yk = 224 - 5 * (k - 23);
            add(1, 1, 0, 0, (k < 39) ? 192 + 5 * k : 384, yk, 1, 1);
        end
        add(1, 1, 0, 0, 379, 139, 1, 1);
        for (int m = 1; m <= 40; m++) begin
            if (m < 28)       yk = 139 - 5 * m;
            else if (m == 28) yk = 0;
            else              yk = 5 * (m - 28);
            add(1, 1, 0, 0, 379 - 5 * m, yk, 1, 1);
        end

        drive_idle();
        reset_n = 1'b0;
        #13;
        chk(bus_a.win_x == 11'd192 && bus_a.win_y == 10'd0 && !bus_a.win_visible && !bus_a.settled,
            $sformatf("reset_state: got x=%0d y=%0d vis=%0b set=%0b, want 192 0 0 0",
                      bus_a.win_x, bus_a.win_y, bus_a.win_visible, bus_a.settled));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Frame stability on instance A: positions move only on frame_tick edges.
        @(negedge clk);
        drive_idle();
        bus_a.win_trigger = 1;
        @(posedge clk);
        #1;
        chk(bus_a.win_visible == 1'b1,
            $sformatf("stab_trigger: got vis=%0b, want 1", bus_a.win_visible));
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            drive_idle();
            ft = ($urandom_range(0, 7) == 0);
            bus_a.frame_tick = ft;
            px = int'(bus_a.win_x);
            py = int'(bus_a.win_y);
            @(posedge clk);
            #1;
            if (!ft)
                chk(int'(bus_a.win_x) == px && int'(bus_a.win_y) == py,
                    $sformatf("stab_hold[%0d]: got x=%0d y=%0d, want x=%0d y=%0d",
                              c, bus_a.win_x, bus_a.win_y, px, py));
            else
                chk(int'(bus_a.win_y) != py,
                    $sformatf("stab_move[%0d]: got y=%0d, want change from %0d", c, bus_a.win_y, py));
            chk(int'(bus_a.win_x) <= 384 && int'(bus_a.win_y) <= 224,
                $sformatf("stab_bounds[%0d]: got x=%0d y=%0d, want x<=384 y<=224",
                          c, bus_a.win_x, bus_a.win_y));
        end

        // Asynchronous reset mid-animation, away from any clock edge.
        @(negedge clk);
        drive_idle();
        bus_b.frame_tick = 1;
        @(posedge clk);
        #2;
        chk(bus_b.settled == 1'b1,
            $sformatf("pre_reset_b: got set=%0b, want 1", bus_b.settled));
        reset_n = 1'b0;
        #1;
        chk(bus_a.win_x == 11'd192 && bus_a.win_y == 10'd0 && !bus_a.win_visible && !bus_a.settled,
            $sformatf("async_reset_a: got x=%0d y=%0d vis=%0b set=%0b, want 192 0 0 0",
                      bus_a.win_x, bus_a.win_y, bus_a.win_visible, bus_a.settled));
        chk(bus_b.win_x == 11'd192 && bus_b.win_y == 10'd0 && !bus_b.win_visible && !bus_b.settled,
            $sformatf("async_reset_b: got x=%0d y=%0d vis=%0b set=%0b, want 192 0 0 0",
                      bus_b.win_x, bus_b.win_y, bus_b.win_visible, bus_b.settled));
        @(negedge clk);
        drive_idle();
        reset_n = 1'b1;
        bus_a.frame_tick = 1;
        @(posedge clk);
        #1;
        chk(bus_a.win_x == 11'd192 && bus_a.win_y == 10'd0 && !bus_a.win_visible,
            $sformatf("post_reset_idle_tick: got x=%0d y=%0d vis=%0b, want 192 0 0",
                      bus_a.win_x, bus_a.win_y, bus_a.win_visible));
        drive_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
